nn_move_selector: RTL and testbench
===================================

// Module: nn_move_selector
// PURPOSE
//  Picks the NN move from the final-layer output: the best-scoring legal board cell.
//  Input: per-cell signed scores and an occupancy mask (P1|P2). Masks occupied cells,
//    scans cells sequentially, returns the winning index on a valid/ready handshake.
//  Sits between the last network receive port and the game-board button driver.
//  Generalised in cell count, score width, max/min mode; backpressure; full-board flag.
// PARAMETERS
//  NUM_CELLS  9                    number of board cells / scores per request
//  SCORE_W    7                    bits per signed (two's complement) score
//  IDX_W      $clog2(NUM_CELLS)    width of cell index (4 for 9 cells)
// PORTS
//  Clk         in   1                    clock, rising edge
//  reset       in   1                    async, active-high; clears all state
//  in_valid    in   1                    request present
//  in_ready    out  1                    block can accept (high only in IDLE)
//  in_scores   in   NUM_CELLS*SCORE_W    cell i at [i*SCORE_W +: SCORE_W], signed
//  in_occupied in   NUM_CELLS            1 = cell taken, excluded from selection
//  select_min  in   1                    0 = pick max score, 1 = pick min score
//  out_valid   out  1                    result present
//  out_ready   in   1                    consumer takes result
//  out_idx     out  IDX_W                selected cell index
//  out_score   out  SCORE_W              score of selected cell
//  out_none    out  1                    1 = every cell occupied, no legal move
//  busy        out  1                    high in SCAN or DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_idx=0,
//    out_score=0, out_none=0, busy=0. In-flight request discarded; no partial result.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready at edge: latch in_scores, in_occupied,
//    select_min; clear cnt, found, best; go SCAN.
//  SCAN: one cell per cycle, cnt = 0..NUM_CELLS-1. Cell cnt is a candidate iff
//    occ[cnt]==0. Candidate replaces best iff !found, or score>=best (max mode),
//    or score<=best (min mode). Compare is signed. Ties go to the HIGHER index.
//    On replace: best<=score, best_idx<=cnt, found<=1.
//    At cnt==NUM_CELLS-1: go DONE; cnt does not wrap.
//  DONE: out_valid=1; out_idx=best_idx, out_score=best, out_none=!found.
//    If !found: out_idx=0, out_score=0.
//    Outputs held stable while out_valid & !out_ready.
//    out_valid&out_ready at edge: go IDLE; out_valid drops next cycle.
//  Latency: accept edge at cycle 0; out_valid high at cycle NUM_CELLS+1.
//    Throughput: one request per NUM_CELLS+2 cycles with out_ready tied high.
//  in_valid while busy: ignored, not queued (in_ready=0). Input busses are
//    don't-care outside the accept edge.
//  Outputs are registered; no combinational path from in_* or out_ready.
//  Occupancy changes after accept have no effect on the in-flight result.
// TESTING
//  1 Empty board; all scores -64; cell4=+63; max mode -> out_idx=4, out_score=63,
//    out_none=0, out_valid 10 cycles after accept.
//  2 Same scores, occ=9'b000010000; cell2=20 is next best -> out_idx=2, out_score=20.
//  3 Tie: cells 1 and 7 both +5, all others -3, empty board -> out_idx=7.
//    Same stimulus with select_min=1 -> out_idx=8, out_score=-3.
//  4 occ=9'h1FF -> out_none=1, out_idx=0, out_score=0, out_valid still asserted.
//  5 Hold out_ready=0 for 5 cycles in DONE; pulse in_valid -> outputs stable,
//    in_ready=0, request ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//  6 Assert reset during SCAN at cnt=4 -> all outputs at reset values immediately;
//    after release, new request runs to a correct result with no stale best/idx.

Source files
------------

// File: rtl/nn_move_selector.sv
// ---------------------------------------------------------------------------
// nn_move_selector
//   Picks the network's move from the final-layer output: the best-scoring
//   cell that is not already occupied. A request carries one signed score per
//   cell and an occupancy mask. The block walks the cells one per clock and
//   hands back the winning index over a valid/ready handshake.
//
//   Ports
//     Clk          rising-edge clock
//     reset        asynchronous, active-high; discards any in-flight request
//     in_valid     request present
//     in_ready     request accepted on this edge when high (IDLE only)
//     in_scores    cell i at [i*SCORE_W +: SCORE_W], two's complement
//     in_occupied  1 = cell taken, never selected
//     select_min   0 = choose the highest score, 1 = choose the lowest
//     out_valid    result present, held until out_ready
//     out_ready    consumer takes the result
//     out_idx      selected cell (0 when no legal move)
//     out_score    score of selected cell (0 when no legal move)
//     out_none     every cell occupied, no legal move
//     busy         scanning or holding a result
// ---------------------------------------------------------------------------
module nn_move_selector #(
    parameter int NUM_CELLS = 9,
    parameter int SCORE_W   = 7,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CELLS*SCORE_W-1:0] in_scores,
    input  logic [NUM_CELLS-1:0]         in_occupied,
    input  logic                         select_min,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_idx,
    output logic [SCORE_W-1:0]           out_score,
    output logic                         out_none,
    output logic                         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    state_t                       state_q,     state_d;
    logic [IDX_W-1:0]             cnt_q,       cnt_d;
    logic                         found_q,     found_d;
    logic signed [SCORE_W-1:0]    best_q,      best_d;
    logic [IDX_W-1:0]             best_idx_q,  best_idx_d;
    logic [NUM_CELLS*SCORE_W-1:0] scores_q,    scores_d;
    logic [NUM_CELLS-1:0]         occ_q,       occ_d;
    logic                         min_q,       min_d;
    logic                         out_valid_q, out_valid_d;
    logic [IDX_W-1:0]             out_idx_q,   out_idx_d;
    logic [SCORE_W-1:0]           out_score_q, out_score_d;
    logic                         out_none_q,  out_none_d;

    // Latched scores viewed as a signed array so the scan can index by cnt.
    logic signed [SCORE_W-1:0] cell_score [NUM_CELLS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_unpack
            assign cell_score[gi] = scores_q[gi*SCORE_W +: SCORE_W];
        end
    endgenerate

    logic signed [SCORE_W-1:0] cur_score;
    logic                      take_cand;

    always_comb begin
        cur_score = cell_score[cnt_q];
        // Non-strict compare so that on a tie the later (higher) index wins.
        take_cand = !occ_q[cnt_q] &&
                    (!found_q || (min_q ? (cur_score <= best_q)
                                        : (cur_score >= best_q)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        found_d     = found_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        scores_d    = scores_q;
        occ_d       = occ_q;
        min_d       = min_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_score_d = out_score_q;
        out_none_d  = out_none_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    scores_d   = in_scores;
                    occ_d      = in_occupied;
                    min_d      = select_min;
                    cnt_d      = '0;
                    found_d    = 1'b0;
                    best_d     = '0;
                    best_idx_d = '0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (take_cand) begin
                    best_d     = cur_score;
                    best_idx_d = cnt_q;
                    found_d    = 1'b1;
                end
                if (cnt_q == LAST_IDX) begin
                    // Result registers load from the post-update values so the
                    // final cell is included in this same edge.
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_none_d  = !found_d;
                    out_idx_d   = found_d ? best_idx_d : '0;
                    out_score_d = found_d ? best_d : '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            best_q      <= '0;
            best_idx_q  <= '0;
            scores_q    <= '0;
            occ_q       <= '0;
            min_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_score_q <= '0;
            out_none_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            scores_q    <= scores_d;
            occ_q       <= occ_d;
            min_q       <= min_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_score_q <= out_score_d;
            out_none_q  <= out_none_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_score = out_score_q;
    assign out_none  = out_none_q;

endmodule

// File: tb/tb_nn_move_selector.sv
// ---------------------------------------------------------------------------
// tb_nn_move_selector
//   Directed vectors with hand-computed expectations for nn_move_selector.
// ---------------------------------------------------------------------------
module tb_nn_move_selector;

    localparam int N  = 9;
    localparam int W  = 7;
    localparam int IW = 4;

    logic           Clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_scores = '0;
    logic [N-1:0]   in_occupied = '0;
    logic           select_min = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [IW-1:0]  out_idx;
    logic [W-1:0]   out_score;
    logic           out_none;
    logic           busy;

    nn_move_selector #(.NUM_CELLS(N), .SCORE_W(W), .IDX_W(IW)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_scores   (in_scores),
        .in_occupied (in_occupied),
        .select_min  (select_min),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_score   (out_score),
        .out_none    (out_none),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sc [N];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) sc[i] = v;
    endtask

    task automatic set_scores();
        for (int i = 0; i < N; i++) in_scores[i*W +: W] = W'(sc[i]);
    endtask

    task automatic check_result(input string tag, input int e_idx,
                                input int e_score, input int e_none);
        check({tag, ".valid"}, int'(out_valid), 1);
        check({tag, ".idx"},   int'(out_idx), e_idx);
        check({tag, ".score"}, int'($signed(out_score)), e_score);
        check({tag, ".none"},  int'(out_none), e_none);
        check({tag, ".in_ready_busy"}, int'(in_ready), 0);
    endtask

    // One request from accept to handshake. Inputs are scrambled right after
    // the accept edge to prove the block works from its latched copy.
    task automatic run_req(input string tag, input logic [N-1:0] occ,
                           input logic mn, input bit hold, input int e_idx,
                           input int e_score, input int e_none);
        int lat;
        @(negedge Clk);
        check({tag, ".in_ready"}, int'(in_ready), 1);
        set_scores();
        in_occupied = occ;
        select_min  = mn;
        in_valid    = 1'b1;
        out_ready   = !hold;
        @(posedge Clk);
        @(negedge Clk);
        in_valid    = 1'b0;
        in_scores   = ~in_scores;
        in_occupied = ~occ;
        select_min  = !mn;
        check({tag, ".busy"}, int'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        // Valid after 9 edges past the accept edge: cycle 10 counting the
        // accept cycle as cycle 0.
        check({tag, ".latency"}, lat, 9);
        check_result(tag, e_idx, e_score, e_none);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                in_valid  = 1'b1;
                in_scores = ~in_scores;
                @(posedge Clk);
                @(negedge Clk);
                check_result({tag, ".hold"}, e_idx, e_score, e_none);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
        check({tag, ".drop_valid"}, int'(out_valid), 0);
        check({tag, ".back_idle"},  int'(in_ready), 1);
        check({tag, ".not_busy"},   int'(busy), 0);
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset.in_ready",  int'(in_ready), 1);
        check("reset.out_valid", int'(out_valid), 0);
        check("reset.out_idx",   int'(out_idx), 0);
        check("reset.out_score", int'(out_score), 0);
        check("reset.out_none",  int'(out_none), 0);
        check("reset.busy",      int'(busy), 0);
        reset = 1'b0;

        // 1: single peak at cell 4
        fill(-64); sc[4] = 63;
        run_req("t1_max", 9'h000, 1'b0, 1'b0, 4, 63, 0);
        $display("t1: idx=%0d score=%0d", out_idx, $signed(out_score));

        // 2: peak cell occupied, next best is cell 2
        fill(-64); sc[4] = 63; sc[2] = 20;
        run_req("t2_occ", 9'b000010000, 1'b0, 1'b0, 2, 20, 0);
        $display("t2: idx=%0d score=%0d", out_idx, $signed(out_score));

        // 3: ties resolve to the higher index in both modes
        fill(-3); sc[1] = 5; sc[7] = 5;
        run_req("t3_tie_max", 9'h000, 1'b0, 1'b0, 7, 5, 0);
        $display("t3a: idx=%0d score=%0d", out_idx, $signed(out_score));
        run_req("t3_tie_min", 9'h000, 1'b1, 1'b0, 8, -3, 0);
        $display("t3b: idx=%0d score=%0d", out_idx, $signed(out_score));

        // 4: full board
        fill(10);
        run_req("t4_full", 9'h1FF, 1'b0, 1'b0, 0, 0, 1);
        $display("t4: none=%0d idx=%0d", out_none, out_idx);

        // all-negative scores: signed compare, occupied duplicate at cell 6
        sc = '{-20, -30, -2, -50, -60, -9, -2, -40, -64};
        run_req("t_signed", 9'b001000000, 1'b0, 1'b0, 2, -2, 0);
        $display("t_signed: idx=%0d score=%0d", out_idx, $signed(out_score));

        // 5: backpressure with in_valid pulsed while holding a result
        fill(-64); sc[4] = 63;
        run_req("t5_hold", 9'h000, 1'b0, 1'b1, 4, 63, 0);
        $display("t5: idx=%0d score=%0d", out_idx, $signed(out_score));

        // 6: reset mid-scan (cnt=4), then a fresh request
        fill(50); sc[3] = -60;
        set_scores();
        @(negedge Clk);
        in_occupied = '0;
        select_min  = 1'b0;
        in_valid    = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        #1;
        check("t6_rst.in_ready",  int'(in_ready), 1);
        check("t6_rst.busy",      int'(busy), 0);
        check("t6_rst.out_valid", int'(out_valid), 0);
        check("t6_rst.out_idx",   int'(out_idx), 0);
        check("t6_rst.out_score", int'(out_score), 0);
        check("t6_rst.out_none",  int'(out_none), 0);
        @(negedge Clk);
        reset = 1'b0;
        fill(-3); sc[1] = 5; sc[7] = 5;
        run_req("t6_after", 9'h000, 1'b1, 1'b0, 8, -3, 0);
        $display("t6: idx=%0d score=%0d", out_idx, $signed(out_score));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
